display_scan_mux: RTL and testbench
===================================

// Module: display_scan_mux
// PURPOSE
//  Time-multiplexed scanner feeding the seven-segment decoder: holds a packed NUM_DIGITS x 4-bit value,
//  presents one nibble at a time on digit_code (bit3..0 -> decoder A,B,C,D) and drives the matching
//  active-low anode. Inserts dead time between digits (anti-ghosting), suppresses leading zeros, and
//  applies new values only at frame boundaries (no tearing).
// PARAMETERS
//  NUM_DIGITS    4      digits scanned; digit 0 = value[3:0] = rightmost = anode_n[0]
//  REFRESH_DIV   50000  clk cycles each digit is lit (SHOW); >= 1
//  BLANK_CYCLES  16     clk cycles all anodes off between digits (BLANK); 0 = no BLANK state
// PORTS
//  clk         in   1             system clock, all logic on rising edge
//  rst_n       in   1             asynchronous active-low reset
//  enable      in   1             1 = scan; 0 = all anodes off, scanner parked
//  lz_en       in   1             1 = leading-zero suppression on
//  value_in    in   4*NUM_DIGITS  packed digits, sampled when load=1
//  load        in   1             1-cycle request to update the displayed value
//  load_ack    out  1             1-cycle pulse when the pending value becomes the displayed value
//  frame_tick  out  1             1-cycle pulse at end of last digit's slot
//  digit_code  out  4             nibble to the decoder for the current digit
//  anode_n     out  NUM_DIGITS    active-low digit enables, at most one low
// BEHAVIOUR
//  Reset: state=IDLE, idx=0, cnt=0, disp=0, shadow=0, pend=0; anode_n all 1, digit_code=0,
//   load_ack=0, frame_tick=0. All outputs registered.
//  FSM: IDLE -> (enable) SHOW ; SHOW -> (cnt==REFRESH_DIV-1) BLANK, or next SHOW if BLANK_CYCLES==0 ;
//   BLANK -> (cnt==BLANK_CYCLES-1) SHOW. Any state -> IDLE when enable=0 (same edge), idx:=0, cnt:=0.
//  cnt resets to 0 on every state entry; width $clog2(max(REFRESH_DIV,BLANK_CYCLES)+1).
//  idx advances (mod NUM_DIGITS) and digit_code updates on SHOW exit, so the code is settled through BLANK.
//  anode_n[idx]=0 only in SHOW and only if digit not suppressed; all 1 in IDLE/BLANK.
//  Suppression (lz_en=1): digit i>0 dark if disp digit i and all digits above it are 0.
//   Digit 0 always lit (value 0 shows "0"). Timing is unchanged for dark digits (constant frame rate).
//  load: shadow:=value_in, pend:=1; later load before boundary overwrites shadow (latest wins, one ack).
//  Frame boundary = SHOW exit of idx NUM_DIGITS-1, or IDLE->SHOW entry. There: frame_tick=1 (SHOW exit
//   only); if pend, disp:=shadow, pend:=0, load_ack=1 in the same cycle. load on the boundary cycle
//   itself bypasses: value_in applied directly, ack pulses, pend stays 0.
//  While IDLE a load stays pending; applied on the IDLE->SHOW edge.
//  Reset mid-scan: immediate return to reset values; a pending load is discarded, no ack.
// STRUCTURE
//  Package display_pkg: typedef digit_t (4-bit), state enum {IDLE,SHOW,BLANK}, DIGIT_W=4.
//  One sub-module natural: lz_mask (combinational, disp + lz_en -> NUM_DIGITS dark mask).
//  Output digit_code connects to the decoder; no other consumers.
// TESTING (NUM_DIGITS=4, REFRESH_DIV=4, BLANK_CYCLES=2)
//  1 reset, enable=1, load 0x1234 -> ack on next boundary; anode_n cycles 1110,1111,1101,1111,1011,...
//    code 4,3,2,1; each lit 4 cycles, dark 2; frame_tick every 24 cycles.
//  2 lz_en=1, load 0x0050 -> digits 0,1 lit (codes 0,5); anode_n stays 1111 during digit 2,3 slots;
//    load 0x0000 -> only digit 0 lit with code 0.
//  3 load 0xAAAA then 0x5555 mid-frame -> single load_ack at boundary, 0x5555 shown, 0xAAAA never shown.
//  4 load coincident with frame_tick -> load_ack same cycle, new value from digit 0 of next frame.
//  5 enable->0 during digit 2 SHOW -> next edge anode_n=1111; re-enable -> restarts at digit 0, full 4-cycle SHOW.
//  6 rst_n low mid-SHOW with load pending -> outputs at reset values asynchronously; no load_ack after release.

Source files
------------

// File: rtl/display_pkg.sv
// Shared types and constants for the seven-segment scan multiplexer.
package display_pkg;

    localparam int DIGIT_W = 4;

    typedef logic [DIGIT_W-1:0] digit_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHOW  = 2'd1,
        BLANK = 2'd2
    } state_e;

    // Used to size the shared slot counter for whichever phase is longer.
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/display_scan_mux_lz_mask.sv
// Leading-zero dark mask: a digit above digit 0 goes dark when it and every
// digit above it are zero. Digit 0 is never dark so a zero value still shows "0".
module lz_mask
    import display_pkg::*;
#(
    parameter int NUM_DIGITS = 4
)(
    input  logic [NUM_DIGITS*DIGIT_W-1:0] disp_i,
    input  logic                          lz_en_i,
    output logic [NUM_DIGITS-1:0]         dark_o
);

    logic zero_above;

    // Walk from the most significant digit down, accumulating "all zero so far".
    always_comb begin
        dark_o     = '0;
        zero_above = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_above = zero_above & (disp_i[i*DIGIT_W +: DIGIT_W] == '0);
            dark_o[i]  = lz_en_i & zero_above & (i > 0);
        end
    end

endmodule

// File: rtl/display_scan_mux.sv
// Time-multiplexed seven-segment scanner with dead time between digits,
// leading-zero suppression and frame-synchronous value updates.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | scanner parked, all anodes off; next enable starts a frame
//   SHOW  | digit idx lit (unless suppressed) for REFRESH_DIV cycles
//   BLANK | all anodes off for BLANK_CYCLES cycles, next code already set
module display_scan_mux
    import display_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 16
)(
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          enable,
    input  logic                          lz_en,
    input  logic [NUM_DIGITS*DIGIT_W-1:0] value_in,
    input  logic                          load,
    output logic                          load_ack,
    output logic                          frame_tick,
    output logic [DIGIT_W-1:0]            digit_code,
    output logic [NUM_DIGITS-1:0]         anode_n
);

    localparam int VAL_W     = NUM_DIGITS * DIGIT_W;
    localparam int CNT_W     = $clog2(max_int(REFRESH_DIV, BLANK_CYCLES) + 1);
    localparam int IDX_W     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam bit HAS_BLANK = (BLANK_CYCLES > 0);

    localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = HAS_BLANK ? CNT_W'(BLANK_CYCLES - 1) : '0;
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_DIGITS - 1);

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [VAL_W-1:0]      disp_q, disp_d;
    logic [VAL_W-1:0]      shadow_q, shadow_d;
    logic                  pend_q, pend_d;

    logic                  load_ack_q, load_ack_d;
    logic                  frame_tick_q, frame_tick_d;
    digit_t                digit_code_q, digit_code_d;
    logic [NUM_DIGITS-1:0] anode_n_q, anode_n_d;

    logic                  boundary;
    logic [NUM_DIGITS-1:0] dark;

    // Dark mask is evaluated on the value that will be displayed after this edge,
    // so a freshly applied value is suppressed correctly from its first cycle.
    lz_mask #(
        .NUM_DIGITS (NUM_DIGITS)
    ) u_lz_mask (
        .disp_i  (disp_d),
        .lz_en_i (lz_en),
        .dark_o  (dark)
    );

    // Next-state: scan sequencing, slot counter, and frame-boundary value hand-off.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        disp_d       = disp_q;
        shadow_d     = shadow_q;
        pend_d       = pend_q;
        load_ack_d   = 1'b0;
        frame_tick_d = 1'b0;
        boundary     = 1'b0;

        if (!enable) begin
            state_d = IDLE;
            cnt_d   = '0;
            idx_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d  = SHOW;
                    cnt_d    = '0;
                    idx_d    = '0;
                    boundary = 1'b1;
                end
                SHOW: begin
                    if (cnt_q == SHOW_LAST) begin
                        state_d = HAS_BLANK ? BLANK : SHOW;
                        cnt_d   = '0;
                        if (idx_q == LAST_IDX) begin
                            idx_d        = '0;
                            boundary     = 1'b1;
                            frame_tick_d = 1'b1;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                BLANK: begin
                    if (cnt_q == BLANK_LAST) begin
                        state_d = SHOW;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
            endcase
        end

        // A load landing exactly on the boundary skips the shadow and is taken directly.
        if (boundary) begin
            if (load) begin
                disp_d     = value_in;
                pend_d     = 1'b0;
                load_ack_d = 1'b1;
            end else if (pend_q) begin
                disp_d     = shadow_q;
                pend_d     = 1'b0;
                load_ack_d = 1'b1;
            end
        end else if (load) begin
            shadow_d = value_in;
            pend_d   = 1'b1;
        end
    end

    // Output decode from next-state so every output leaves a flop.
    always_comb begin
        anode_n_d    = '1;
        digit_code_d = disp_d[int'(idx_d)*DIGIT_W +: DIGIT_W];
        if (state_d == SHOW && !dark[idx_d]) begin
            anode_n_d[idx_d] = 1'b0;
        end
    end

    // Scanner state and value registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            disp_q   <= '0;
            shadow_q <= '0;
            pend_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            disp_q   <= disp_d;
            shadow_q <= shadow_d;
            pend_q   <= pend_d;
        end
    end

    // Registered outputs to the segment decoder and anode drivers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            anode_n_q    <= '1;
            digit_code_q <= '0;
            load_ack_q   <= 1'b0;
            frame_tick_q <= 1'b0;
        end else begin
            anode_n_q    <= anode_n_d;
            digit_code_q <= digit_code_d;
            load_ack_q   <= load_ack_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign anode_n    = anode_n_q;
    assign digit_code = digit_code_q;
    assign load_ack   = load_ack_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_display_scan_mux.sv
// Directed bench for display_scan_mux: expected per-cycle outputs are queued
// as stimulus is planned and popped against the DUT every cycle.
module tb_display_scan_mux;

    localparam int NUM_DIGITS   = 4;
    localparam int REFRESH_DIV  = 4;
    localparam int BLANK_CYCLES = 2;
    localparam int SLOT         = REFRESH_DIV + BLANK_CYCLES;
    localparam int FRAME        = NUM_DIGITS * SLOT;
    localparam int TICK_K       = FRAME - BLANK_CYCLES;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic        lz_en;
    logic [15:0] value_in;
    logic        load;
    logic        load_ack;
    logic        frame_tick;
    logic [3:0]  digit_code;
    logic [3:0]  anode_n;

    typedef struct {
        logic [3:0] anode;
        logic [3:0] code;
        logic       tick;
        logic       ack;
    } exp_t;

    exp_t exp_q[$];
    int   checks;
    int   errors;
    int   cyc;

    display_scan_mux #(
        .NUM_DIGITS   (NUM_DIGITS),
        .REFRESH_DIV  (REFRESH_DIV),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .lz_en      (lz_en),
        .value_in   (value_in),
        .load       (load),
        .load_ack   (load_ack),
        .frame_tick (frame_tick),
        .digit_code (digit_code),
        .anode_n    (anode_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] nib(input logic [15:0] v, input int d);
        return v[d*4 +: 4];
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    // Expected outputs for the first nk cycles of a frame showing val;
    // nxt is the value whose digit 0 appears in the final BLANK.
    task automatic push_frame(input logic [15:0] val, input logic [15:0] nxt, input logic lz,
                              input logic ack0, input logic ack_end, input int nk);
        exp_t e;
        for (int k = 0; k < nk; k++) begin
            int d;
            int r;
            d = k / SLOT;
            r = k % SLOT;
            e.tick = (k == TICK_K);
            e.ack  = (k == 0 && ack0) || (k == TICK_K && ack_end);
            if (r < REFRESH_DIV) begin
                e.code = nib(val, d);
                if (lz && d > 0 && (val >> (4*d)) == 16'h0) e.anode = 4'hF;
                else                                        e.anode = ~(4'b0001 << d);
            end else begin
                e.anode = 4'hF;
                e.code  = (d < NUM_DIGITS - 1) ? nib(val, d + 1) : nib(nxt, 0);
            end
            exp_q.push_back(e);
        end
    endtask

    task automatic push_idle(input int n, input logic [3:0] code);
        exp_t e;
        for (int k = 0; k < n; k++) begin
            e.anode = 4'hF;
            e.code  = code;
            e.tick  = 1'b0;
            e.ack   = 1'b0;
            exp_q.push_back(e);
        end
    endtask

    task automatic step(input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            cyc++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL scoreboard cycle=%0d observed=empty expected=entry", cyc);
            end else begin
                e = exp_q.pop_front();
                chk("anode_n",    {12'h0, anode_n},    {12'h0, e.anode});
                chk("digit_code", {12'h0, digit_code}, {12'h0, e.code});
                chk("frame_tick", {15'h0, frame_tick}, {15'h0, e.tick});
                chk("load_ack",   {15'h0, load_ack},   {15'h0, e.ack});
            end
        end
    endtask

    task automatic chk_reset(input string pfx);
        chk({pfx, "_anode_n"},    {12'h0, anode_n},    16'h000F);
        chk({pfx, "_digit_code"}, {12'h0, digit_code}, 16'h0000);
        chk({pfx, "_load_ack"},   {15'h0, load_ack},   16'h0000);
        chk({pfx, "_frame_tick"}, {15'h0, frame_tick}, 16'h0000);
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        cyc      = 0;
        rst_n    = 1'b0;
        enable   = 1'b0;
        lz_en    = 1'b0;
        load     = 1'b0;
        value_in = 16'h0;

        repeat (3) @(negedge clk);
        chk_reset("reset");
        rst_n = 1'b1;

        // Load while parked stays pending, then lands on the IDLE->SHOW edge.
        load     = 1'b1;
        value_in = 16'h1234;
        push_idle(1, 4'h0);
        step(1);
        load   = 1'b0;
        enable = 1'b1;
        push_frame(16'h1234, 16'h1234, 1'b0, 1'b1, 1'b0, FRAME);
        step(FRAME);
        push_frame(16'h1234, 16'h1234, 1'b0, 1'b0, 1'b0, FRAME);
        step(FRAME);

        // Leading-zero suppression: 0x0050 then 0x0000.
        lz_en = 1'b1;
        push_frame(16'h1234, 16'h0050, 1'b1, 1'b0, 1'b1, FRAME);
        step(5);
        load = 1'b1; value_in = 16'h0050;
        step(1);
        load = 1'b0;
        step(FRAME - 6);

        push_frame(16'h0050, 16'h0000, 1'b1, 1'b0, 1'b1, FRAME);
        step(8);
        load = 1'b1; value_in = 16'h0000;
        step(1);
        load = 1'b0;
        step(FRAME - 9);

        // Two loads in one frame: only the later one is shown, one ack.
        push_frame(16'h0000, 16'h5555, 1'b1, 1'b0, 1'b1, FRAME);
        step(3);
        load = 1'b1; value_in = 16'hAAAA;
        step(1);
        load = 1'b0;
        step(6);
        load = 1'b1; value_in = 16'h5555;
        step(1);
        load = 1'b0;
        step(FRAME - 11);

        // Load on the boundary edge itself is applied directly.
        push_frame(16'h5555, 16'h9876, 1'b1, 1'b0, 1'b1, FRAME);
        step(TICK_K);
        load = 1'b1; value_in = 16'h9876;
        step(1);
        load = 1'b0;
        step(FRAME - TICK_K - 1);
        push_frame(16'h9876, 16'h9876, 1'b1, 1'b0, 1'b0, FRAME);
        step(FRAME);

        // Disable mid digit 2 SHOW, then restart from digit 0.
        push_frame(16'h9876, 16'h9876, 1'b1, 1'b0, 1'b0, 2*SLOT + 2);
        step(2*SLOT + 2);
        enable = 1'b0;
        push_idle(3, 4'h6);
        step(3);
        enable = 1'b1;
        push_frame(16'h9876, 16'h9876, 1'b1, 1'b0, 1'b0, FRAME);
        step(FRAME);

        // Asynchronous reset mid-SHOW with a load pending.
        push_frame(16'h9876, 16'h9876, 1'b1, 1'b0, 1'b0, 3);
        step(2);
        load = 1'b1; value_in = 16'h1111;
        step(1);
        load  = 1'b0;
        rst_n = 1'b0;
        #1;
        chk_reset("async_reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        push_frame(16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, FRAME);
        step(FRAME);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
